// File: rtl/alu_seq_nbit.sv
// Registered signed ALU: single-cycle add/sub/max and an N-cycle sign-magnitude
// shift-add multiply behind a start/busy/done handshake.
module alu_seq_nbit #(
    parameter int unsigned N = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [1:0]     sel,
    output logic [2*N-1:0] y,
    output logic           done,
    output logic           busy,
    output logic           zero
);

    localparam int unsigned W      = 2 * N;
    localparam int unsigned LAST_I = N - 1;
    localparam logic [N-1:0] LAST  = LAST_I[N-1:0];

    typedef enum logic {IDLE, MUL} state_t;

    state_t         r_state;
    logic [W-1:0]   r_mcand;
    logic [N-1:0]   r_mplier;
    logic [W-1:0]   r_acc;
    logic [N-1:0]   r_cnt;
    logic           r_sign;

    logic [N:0]     w_sum;
    logic [N:0]     w_diff;
    logic [N:0]     w_addsub;
    logic [N-1:0]   w_max;
    logic [W-1:0]   w_single;
    logic [N-1:0]   w_abs_a;
    logic [N-1:0]   w_abs_b;
    logic [W-1:0]   w_acc_next;
    logic [W-1:0]   w_mul_res;

    always_comb begin
        w_sum      = {a[N-1], a} + {b[N-1], b};
        w_diff     = {a[N-1], a} - {b[N-1], b};
        w_addsub   = sel[0] ? w_diff : w_sum;
        w_max      = ($signed(a) >= $signed(b)) ? a : b;
        w_single   = sel[1] ? {{N{w_max[N-1]}}, w_max}
                            : {{(N-1){w_addsub[N]}}, w_addsub};
        // N-bit negation of -2^(N-1) yields 2^(N-1), which is exact when read unsigned
        w_abs_a    = a[N-1] ? -a : a;
        w_abs_b    = b[N-1] ? -b : b;
        w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_mul_res  = r_sign ? -w_acc_next : w_acc_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            y        <= '0;
            zero     <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (sel == 2'b10) begin
                            r_mcand  <= {{N{1'b0}}, w_abs_a};
                            r_mplier <= w_abs_b;
                            r_sign   <= a[N-1] ^ b[N-1];
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            busy     <= 1'b1;
                            r_state  <= MUL;
                        end else begin
                            y    <= w_single;
                            zero <= (w_single == '0);
                            done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    // Multiplicand is pre-shifted each iteration instead of shifting by r_cnt
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        y       <= w_mul_res;
                        zero    <= (w_mul_res == '0);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
